// File: rtl/alu_test_pkg.sv
// Shared types and constants for the ALU test design: widths, FSM encoding,
// and the default key debounce length.
package alu_test_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int RES_W  = 16;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [5:0] {
        S_ENTER_A  = 6'b000001,
        S_ENTER_B  = 6'b000010,
        S_ENTER_OP = 6'b000100,
        S_ISSUE    = 6'b001000,
        S_WAIT_RES = 6'b010000,
        S_SHOW     = 6'b100000
    } state_t;

    // ISSUE and WAIT_RES share one LED so the board shows "busy with the ALU".
    function automatic logic [4:0] leds_of(input state_t s);
        return {s[5], s[4] | s[3], s[2], s[1], s[0]};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on every accepted press (high-to-low flip).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            level_reg   <= 1'b1;
            level_d_reg <= 1'b1;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            // Pulse is taken from the delayed accepted level so it is a clean register output.
            level_d_reg <= level_reg;
            press_reg   <= level_d_reg & ~level_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/alu_input_sequencer.sv
// Operand-entry front end for the ALU: debounced keys step an FSM that latches
// A, B and the opcode from the switches, issues one request and shows the result.
module alu_input_sequencer
    import alu_test_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    input  logic [1:0]        KEY,
    input  logic [DATA_W-1:0] SW,
    input  logic              alu_ready,
    input  logic              res_valid,
    input  logic [RES_W-1:0]  alu_result,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_valid,
    output logic [RES_W-1:0]  disp_value,
    output logic [4:0]        state_leds
);

    logic [1:0] press;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk    (CLOCK_50),
                .rst_n  (Resetn),
                .key_raw(KEY[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    logic enter;
    logic cancel;
    assign enter  = press[0];
    assign cancel = press[1];

    state_t            state_reg,  state_next;
    logic [DATA_W-1:0] op_a_reg,   op_a_next;
    logic [DATA_W-1:0] op_b_reg,   op_b_next;
    logic [OP_W-1:0]   alu_op_reg, alu_op_next;
    logic [RES_W-1:0]  result_reg, result_next;
    logic              valid_reg,  valid_next;
    logic [RES_W-1:0]  disp_reg,   disp_next;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_reg  <= S_ENTER_A;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            alu_op_reg <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
            disp_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            op_a_reg   <= op_a_next;
            op_b_reg   <= op_b_next;
            alu_op_reg <= alu_op_next;
            result_reg <= result_next;
            valid_reg  <= valid_next;
            disp_reg   <= disp_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_a_next   = op_a_reg;
        op_b_next   = op_b_reg;
        alu_op_next = alu_op_reg;
        result_next = result_reg;
        disp_next   = '0;

        // Cancel is checked first in every state that honours it, so it beats enter.
        unique case (state_reg)
            S_ENTER_A: begin
                if (cancel) begin
                    state_next = S_ENTER_A;
                end else if (enter) begin
                    op_a_next  = SW;
                    state_next = S_ENTER_B;
                end
            end
            S_ENTER_B: begin
                if (cancel) begin
                    state_next = S_ENTER_A;
                end else if (enter) begin
                    op_b_next  = SW;
                    state_next = S_ENTER_OP;
                end
            end
            S_ENTER_OP: begin
                if (cancel) begin
                    state_next = S_ENTER_A;
                end else if (enter) begin
                    alu_op_next = SW[OP_W-1:0];
                    state_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (valid_reg && alu_ready) begin
                    state_next = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    result_next = alu_result;
                    state_next  = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cancel || enter) begin
                    state_next = S_ENTER_A;
                end
            end
            default: state_next = S_ENTER_A;
        endcase

        unique case (state_reg)
            S_ENTER_A, S_ENTER_B: disp_next = {{(RES_W-DATA_W){1'b0}}, SW};
            S_ENTER_OP:           disp_next = {{(RES_W-OP_W){1'b0}}, SW[OP_W-1:0]};
            S_ISSUE, S_WAIT_RES:  disp_next = {op_a_reg, op_b_reg};
            S_SHOW:               disp_next = result_reg;
            default:              disp_next = '0;
        endcase

        valid_next = (state_next == S_ISSUE);
    end

    assign op_a       = op_a_reg;
    assign op_b       = op_b_reg;
    assign alu_op     = alu_op_reg;
    assign alu_valid  = valid_reg;
    assign disp_value = disp_reg;
    assign state_leds = leds_of(state_reg);

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: a history-window key model plus a rule-level
// FSM model compared every cycle, with directed literal checks on top.
module tb_alu_input_sequencer;

    localparam int D = 4;

    logic        CLOCK_50;
    logic        Resetn;
    logic [1:0]  KEY;
    logic [7:0]  SW;
    logic        alu_ready;
    logic        res_valid;
    logic [15:0] alu_result;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  alu_op;
    logic        alu_valid;
    logic [15:0] disp_value;
    logic [4:0]  state_leds;

    alu_input_sequencer #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .KEY       (KEY),
        .SW        (SW),
        .alu_ready (alu_ready),
        .res_valid (res_valid),
        .alu_result(alu_result),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_op    (alu_op),
        .alu_valid (alu_valid),
        .disp_value(disp_value),
        .state_leds(state_leds)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;
    bit run_cmp  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0=ENTER_A 1=ENTER_B 2=ENTER_OP 3=ISSUE 4=WAIT_RES 5=SHOW
    int          m_state;
    logic [7:0]  m_a, m_b;
    logic [3:0]  m_op;
    logic [15:0] m_res, m_disp;
    logic [5:0]  hist [2];
    logic        acc [2];
    logic        fall_d1 [2];
    logic        fall_d2 [2];

    function automatic logic [4:0] leds_exp(input int s);
        case (s)
            0: return 5'b00001;
            1: return 5'b00010;
            2: return 5'b00100;
            3, 4: return 5'b01000;
            default: return 5'b10000;
        endcase
    endfunction

    // A level is accepted once D consecutive raw samples, taken 2..D+1 edges ago, disagree with it.
    always @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_disp = 0;
            for (int k = 0; k < 2; k++) begin
                hist[k] = '1; acc[k] = 1'b1; fall_d1[k] = 1'b0; fall_d2[k] = 1'b0;
            end
        end else begin
            logic ent, can;
            int   ns;
            ent = fall_d2[0];
            can = fall_d2[1];
            for (int k = 0; k < 2; k++) begin
                logic fall_now;
                hist[k] = {hist[k][4:0], KEY[k]};
                fall_now = 1'b0;
                if (hist[k][5:2] == {D{~acc[k]}}) begin
                    acc[k] = ~acc[k];
                    fall_now = (acc[k] == 1'b0);
                end
                fall_d2[k] = fall_d1[k];
                fall_d1[k] = fall_now;
            end
            case (m_state)
                0, 1:    m_disp = {8'h00, SW};
                2:       m_disp = {12'h000, SW[3:0]};
                3, 4:    m_disp = {m_a, m_b};
                default: m_disp = m_res;
            endcase
            ns = m_state;
            if (m_state <= 2 || m_state == 5) begin
                if (can) ns = 0;
                else if (ent) begin
                    if (m_state == 0) m_a = SW;
                    if (m_state == 1) m_b = SW;
                    if (m_state == 2) m_op = SW[3:0];
                    ns = (m_state == 5) ? 0 : m_state + 1;
                end
            end else if (m_state == 3) begin
                if (alu_ready) ns = 4;
            end else if (m_state == 4) begin
                if (res_valid) begin
                    m_res = alu_result;
                    ns = 5;
                end
            end
            m_state = ns;
        end
    end

    always @(negedge CLOCK_50) begin
        if (run_cmp) begin
            chk("cmp_op_a", op_a, m_a);
            chk("cmp_op_b", op_b, m_b);
            chk("cmp_alu_op", alu_op, m_op);
            chk("cmp_alu_valid", alu_valid, m_state == 3);
            chk("cmp_disp", disp_value, m_disp);
            chk("cmp_leds", state_leds, leds_exp(m_state));
            if (alu_valid) vcount++;
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Hold the given keys low for 6 edges, then let the release debounce out.
    task automatic press(input logic [1:0] keys);
        KEY = ~keys;
        repeat (6) step();
        KEY = 2'b11;
        repeat (8) step();
    endtask

    initial begin
        int first;
        Resetn = 1'b1; KEY = 2'b11; SW = 8'h00;
        alu_ready = 1'b0; res_valid = 1'b0; alu_result = 16'h0000;
        #1 Resetn = 1'b0;
        #1 run_cmp = 1'b1;
        repeat (3) step();
        chk("rst_leds", state_leds, 5'b00001);
        chk("rst_op_a", op_a, 8'h00);
        chk("rst_valid", alu_valid, 1'b0);
        chk("rst_disp", disp_value, 16'h0000);
        Resetn = 1'b1;
        repeat (10) step();
        chk("no_spurious_press", state_leds, 5'b00001);

        // 3-cycle glitch must be rejected
        SW = 8'hAA;
        KEY[0] = 1'b0;
        repeat (3) step();
        KEY[0] = 1'b1;
        repeat (10) step();
        chk("glitch_leds", state_leds, 5'b00001);
        chk("glitch_op_a", op_a, 8'h00);

        // pulse after edge 6, latch on edge 7
        SW = 8'h3C;
        first = -1;
        KEY[0] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 5) KEY[0] = 1'b1;
            if (first < 0 && state_leds == 5'b00010) first = i;
        end
        chk("press_latch_edge", first, 7);
        chk("op_a_3c", op_a, 8'h3C);
        repeat (4) step();
        chk("single_press", state_leds, 5'b00010);

        SW = 8'h05;
        press(2'b01);
        chk("op_b_05", op_b, 8'h05);
        chk("leds_enter_op", state_leds, 5'b00100);

        SW = 8'h02;
        alu_ready = 1'b1;
        vcount = 0;
        KEY[0] = 1'b0;
        repeat (6) step();
        KEY[0] = 1'b1;
        step();
        step();
        chk("valid_rise", alu_valid, 1'b1);
        step();
        chk("valid_drop", alu_valid, 1'b0);
        chk("leds_wait", state_leds, 5'b01000);
        alu_ready = 1'b0;
        step();
        step();
        res_valid = 1'b1; alu_result = 16'h0041;
        step();
        res_valid = 1'b0; alu_result = 16'h0000;
        step();
        chk("show_leds", state_leds, 5'b10000);
        chk("show_disp", disp_value, 16'h0041);
        chk("show_op_a", op_a, 8'h3C);
        chk("show_op_b", op_b, 8'h05);
        chk("show_alu_op", alu_op, 4'h2);
        chk("valid_cycles", vcount, 1);
        repeat (6) step();

        press(2'b01);
        chk("show_exit_leds", state_leds, 5'b00001);
        chk("retain_op_a", op_a, 8'h3C);

        // cancel in ENTER_OP
        SW = 8'h11; press(2'b01);
        SW = 8'h22; press(2'b01);
        chk("pre_cancel_leds", state_leds, 5'b00100);
        SW = 8'h09; press(2'b10);
        chk("cancel_op_leds", state_leds, 5'b00001);
        chk("cancel_op_a", op_a, 8'h11);
        chk("cancel_op_b", op_b, 8'h22);
        chk("cancel_alu_op", alu_op, 4'h2);

        // enter and cancel together in ENTER_B
        SW = 8'h33; press(2'b01);
        chk("both_pre_leds", state_leds, 5'b00010);
        SW = 8'h44; press(2'b11);
        chk("both_leds", state_leds, 5'b00001);
        chk("both_op_b", op_b, 8'h22);

        // backpressure, res_valid at transfer ignored, cancel in WAIT_RES ignored
        SW = 8'h44; press(2'b01);
        SW = 8'h55; press(2'b01);
        SW = 8'h07; press(2'b01);
        chk("bp_valid", alu_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            SW = 8'(i * 17);
            step();
            chk("bp_hold_valid", alu_valid, 1'b1);
            chk("bp_hold_ops", {op_a, op_b, alu_op}, {8'h44, 8'h55, 4'h7});
        end
        alu_ready = 1'b1; res_valid = 1'b1; alu_result = 16'hDEAD;
        step();
        alu_ready = 1'b0; res_valid = 1'b0;
        chk("bp_after_xfer_valid", alu_valid, 1'b0);
        step();
        chk("early_res_ignored", state_leds, 5'b01000);
        press(2'b10);
        chk("cancel_wait_ignored", state_leds, 5'b01000);
        res_valid = 1'b1; alu_result = 16'hBEEF;
        step();
        res_valid = 1'b0;
        step();
        chk("bp_show_disp", disp_value, 16'hBEEF);

        // async reset while alu_valid is high
        press(2'b01);
        SW = 8'h66; press(2'b01);
        SW = 8'h77; press(2'b01);
        SW = 8'h01; press(2'b01);
        chk("ar_valid_before", alu_valid, 1'b1);
        Resetn = 1'b0;
        #1;
        chk("ar_valid_now", alu_valid, 1'b0);
        chk("ar_leds_now", state_leds, 5'b00001);
        chk("ar_op_a_now", op_a, 8'h00);
        step();
        step();
        Resetn = 1'b1;
        repeat (3) step();
        chk("ar_leds_after", state_leds, 5'b00001);
        chk("ar_disp_after", disp_value, 16'h0001);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Operand-entry front end for the ALU test design on the DE-series board, sitting directly upstream of the ALU inside `top`. It turns raw pushbutton and switch activity into one validated ALU request: operand A, operand B, opcode. It hands the request over on a valid/ready handshake, captures the returned result and supplies a 16-bit value for the HEX display path. Pushbuttons are synchronised and debounced internally, so the ALU only ever sees clean, single requests.

## Interface
- `DEBOUNCE_CYCLES`, 500000, number of consecutive stable cycles needed before a key level is accepted (10 ms at 50 MHz); benches use 4.
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `Resetn`  in  1  reset, asynchronous, active-low.
- `KEY`  in  2  raw active-low pushbuttons: [0] = enter, [1] = cancel.
- `SW`  in  8  raw switches: operand / opcode source.
- `alu_ready`  in  1  ALU can accept a request.
- `res_valid`  in  1  one-cycle pulse: `alu_result` is valid.
- `alu_result`  in  16  ALU result.
- `op_a`, `op_b`  out  8 each  latched operands.
- `alu_op`  out  4  latched opcode.
- `alu_valid`  out  1  request valid, held until accepted.
- `disp_value`  out  16  value for the HEX decoders.
- `state_leds`  out  5  one-hot state indicator, drives `LEDR[4:0]`.

## Operation
- **Key conditioning**, per key:
  - 2-flop synchroniser.
  - Stable counter: counts while the synchronised level differs from the accepted level; clears to 0 when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the level still differs, the accepted level flips on the next edge and the counter clears.
  - Press event: a one-cycle pulse, registered, on each accepted 1→0 flip. Releases produce no event.
- **FSM**, one-hot states:
  - ENTER_A: enter → `op_a`←`SW`, go to ENTER_B.
  - ENTER_B: enter → `op_b`←`SW`, go to ENTER_OP.
  - ENTER_OP: enter → `alu_op`←`SW[3:0]`, go to ISSUE.
  - ISSUE: `alu_valid`=1. On a cycle with `alu_valid`&`alu_ready`, the transfer completes and the FSM goes to WAIT_RES with `alu_valid`=0 next cycle.
  - WAIT_RES: on `res_valid`, the result register ← `alu_result`, go to SHOW.
  - SHOW: enter → go to ENTER_A. Operands are retained.
- **Cancel:**
  - In ENTER_A, ENTER_B, ENTER_OP or SHOW, cancel → ENTER_A. Latched registers are unchanged.
  - Cancel is ignored in ISSUE and WAIT_RES, so a request cannot be aborted mid-handshake.
  - Enter and cancel pressed in the same cycle: cancel wins.
- `res_valid` outside WAIT_RES is ignored.
- `op_a`, `op_b` and `alu_op` are stable from ISSUE entry until the next latch. The ALU may sample them at the handshake.
- **`disp_value`**, registered:
  - ENTER_A / ENTER_B: {8'h00, `SW`}, live preview.
  - ENTER_OP: {12'h000, `SW[3:0]`}.
  - ISSUE / WAIT_RES: {`op_a`, `op_b`}.
  - SHOW: result register.
- `state_leds` bit order: [0] ENTER_A, [1] ENTER_B, [2] ENTER_OP, [3] ISSUE or WAIT_RES, [4] SHOW.

## Timing
- **Reset values:**
  - State ENTER_A, `state_leds`=5'b00001.
  - `op_a`=`op_b`=0, `alu_op`=0, result register=0, `alu_valid`=0, `disp_value`=0.
  - Accepted key levels=1 (released), counters=0, press pulses=0.
- **Reset mid-operation:** `Resetn` low asynchronously forces all of the above, including dropping `alu_valid` mid-handshake.
- **Debounce latency:** raw key first sampled low at edge 0, held low → press pulse high in the cycle after edge `DEBOUNCE_CYCLES`+2.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.
- **Latch timing:** the register latch and the state change occur on the edge ending the press-pulse cycle.
- **`alu_valid` timing:** rises 1 cycle after ENTER_OP's latching edge. If `alu_ready` is already high, the transfer completes in 1 cycle.
- **`disp_value`:** lags state and `SW` by 1 cycle.
- **Simultaneous events:** `res_valid` in the same cycle as the transfer is ignored, because the FSM is still in ISSUE. The ALU must respond at least 1 cycle after the transfer.

## Structure
- Shared package `alu_test_pkg`:
  - FSM state encoding constants: S_ENTER_A … S_SHOW.
  - `DATA_W`=8, `OP_W`=4, `RES_W`=16.
  - Default `DEBOUNCE_CYCLES`.
- One sub-module, `key_debounce`: synchroniser, counter and press-pulse generation, parameterised by `DEBOUNCE_CYCLES`. It is instantiated twice, once per key.
- FSM, operand registers and display mux live in `alu_input_sequencer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `Resetn`=0, then release → all outputs at the reset values, `state_leds`=5'b00001; no spurious press with `KEY`=2'b11.
- **Full transaction:**
  - Stimulus: `SW`=8'h3C + enter, `SW`=8'h05 + enter, `SW`=8'h02 + enter; `alu_ready`=1; `res_valid` with `alu_result`=16'h0041 three cycles after the transfer.
  - Response: `op_a`=3C, `op_b`=05, `alu_op`=2, `alu_valid` high exactly 1 cycle, `disp_value`=16'h0041, `state_leds`=5'b10000.
- **Debounce:**
  - A 3-cycle low glitch on `KEY[0]` in ENTER_A → no state change.
  - A 6-cycle hold → exactly one press, with the pulse in the cycle after edge 6.
- **Backpressure:** `alu_ready`=0 for 10 cycles in ISSUE → `alu_valid` stays 1 and the operands are stable; `alu_ready`=1 → one transfer, then WAIT_RES.
- **Cancel rules:**
  - Cancel in ENTER_OP → ENTER_A with `op_a`/`op_b` unchanged.
  - Cancel in WAIT_RES → ignored.
  - Enter and cancel in the same cycle in ENTER_B → ENTER_A.
- **Async reset mid-handshake:** `Resetn` pulled low while `alu_valid`=1 → `alu_valid`=0 immediately, without waiting for a clock edge; FSM in ENTER_A after release.
